// File: rtl/mmio_store_responder_if.sv
// mmio_store_responder_if: store-bus, sink-handshake and status signals of the MMIO store responder
interface mmio_store_responder_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic [31:0]            ALUResultX;
  logic [31:0]            RD2X;
  logic                   MemWriteX;
  logic                   out_valid;
  logic [31:0]            out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   drain_en;
  logic [CNT_W-1:0]       store_cnt;
`ifdef MMIO_STORE_READBACK_EN
  logic [31:0]            rdata;
`endif
  modport master (
    output ALUResultX, RD2X, MemWriteX, out_ready,
    input  out_valid, out_data, fifo_count, overflow, drain_en, store_cnt
`ifdef MMIO_STORE_READBACK_EN
    , input rdata
`endif
  );
  modport slave (
    input  ALUResultX, RD2X, MemWriteX, out_ready,
    output out_valid, out_data, fifo_count, overflow, drain_en, store_cnt
`ifdef MMIO_STORE_READBACK_EN
    , output rdata
`endif
  );
endinterface

// File: rtl/mmio_store_responder.sv
// mmio_store_responder: decodes MMIO stores into a FIFO drained over valid/ready.
// Define MMIO_STORE_READBACK_EN to add the combinational load readback mux on rdata.
module mmio_store_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = 16
) (
  input logic                   clk,
  input logic                   reset,
  mmio_store_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_drain_en, r_ovf;
  logic [CNT_W-1:0] r_store_cnt;
  logic             w_win, w_hit, w_data_wr, w_ctrl, w_clr, w_flush;
  logic             w_valid, w_pop, w_full, w_push, w_drop;
  logic [1:0]       w_off;
  logic [31:0]      w_head;
  logic             w_unused;
  assign w_unused  = ^bus.ALUResultX[1:0];
  assign w_win     = bus.ALUResultX[31:4] == BASE_ADDR[31:4];
  assign w_hit     = bus.MemWriteX & w_win;
  assign w_off     = bus.ALUResultX[3:2];
  assign w_data_wr = w_hit & (w_off == 2'd0);
  assign w_ctrl    = w_hit & (w_off == 2'd1);
  assign w_clr     = w_hit & (w_off == 2'd2);
  assign w_flush   = w_ctrl & bus.RD2X[1];
  assign w_valid   = r_drain_en & (r_cnt != '0);
  assign w_pop     = w_valid & bus.out_ready;
  assign w_full    = r_cnt == FULL;
  // A full FIFO still takes a word when the sink frees a slot in the same cycle
  assign w_push    = w_data_wr & (~w_full | w_pop);
  assign w_drop    = w_data_wr & w_full & ~w_pop;
  assign w_head    = r_mem[r_rp];
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_valid ? w_head : '0;
  assign bus.fifo_count = r_cnt;
  assign bus.overflow   = r_ovf;
  assign bus.drain_en   = r_drain_en;
  assign bus.store_cnt  = r_store_cnt;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= bus.RD2X;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_drain_en  <= 1'b0;
      r_ovf       <= 1'b0;
      r_store_cnt <= '0;
    end else begin
      r_wp        <= w_flush ? '0 : r_wp + AW'(w_push);
      r_rp        <= w_flush ? '0 : r_rp + AW'(w_pop);
      r_cnt       <= w_flush ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
      r_drain_en  <= w_ctrl ? bus.RD2X[0] : r_drain_en;
      r_ovf       <= w_drop | (r_ovf & ~w_clr);
      r_store_cnt <= r_store_cnt + CNT_W'(w_push);
    end
  end
`ifdef MMIO_STORE_READBACK_EN
  always_comb begin
    bus.rdata = '0;
    if (w_win)
      bus.rdata = w_off == 2'd0 ? ((r_cnt != '0) ? w_head : '0) :
                  w_off == 2'd1 ? 32'({r_cnt, r_ovf, r_drain_en}) :
                  w_off == 2'd2 ? 32'(r_store_cnt) : '0;
  end
`endif
endmodule

// File: tb/tb_mmio_store_responder.sv
// tb_mmio_store_responder: directed stores checked every cycle against a queue-based model,
// plus hand-computed literal expectations at the interesting points.
module tb_mmio_store_responder;
  localparam logic [31:0] BASE  = 32'h0000_7F00;
  localparam int          DEPTH = 8;
  localparam int          CNT_W = 16;
  localparam logic [31:0] A_DATA = BASE, A_CTRL = BASE + 4, A_OVF = BASE + 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mmio_store_responder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  mmio_store_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  logic [31:0] q[$];
  logic [31:0] mpop[$];
  bit de, ov, on;
  int sc;
  int checks, errs;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // Model: a word queue updated with the store/handshake rules once per rising edge
  task automatic model();
    logic hit;
    logic [1:0] off;
    logic [31:0] d;
    hit = bus.MemWriteX && (bus.ALUResultX[31:4] == BASE[31:4]);
    off = bus.ALUResultX[3:2];
    d = bus.RD2X;
    if (!reset) begin
      q.delete(); de = 0; ov = 0; sc = 0;
      return;
    end
    if (de && q.size() != 0 && bus.out_ready) mpop.push_back(q.pop_front());
    if (hit && off == 0) begin
      if (q.size() < DEPTH) begin q.push_back(d); sc = (sc + 1) % (1 << CNT_W); end
      else ov = 1;
    end
    if (hit && off == 1) begin
      de = d[0];
      if (d[1]) q.delete();
    end
    if (hit && off == 2) ov = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic idle();
    bus.MemWriteX = 1'b0;
    tick();
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    bus.MemWriteX = 1'b1; bus.ALUResultX = a; bus.RD2X = d;
    tick();
    bus.MemWriteX = 1'b0;
  endtask
  always @(negedge clk) if (on) begin
    chk("out_valid", 32'(bus.out_valid), 32'(de && q.size() != 0));
    chk("out_data", bus.out_data, (de && q.size() != 0) ? q[0] : 32'h0);
    chk("fifo_count", 32'(bus.fifo_count), q.size());
    chk("overflow", 32'(bus.overflow), 32'(ov));
    chk("drain_en", 32'(bus.drain_en), 32'(de));
    chk("store_cnt", 32'(bus.store_cnt), sc);
  end
  initial begin
    int s;
    bus.MemWriteX = 0; bus.ALUResultX = 0; bus.RD2X = 0; bus.out_ready = 0;
    tick(); on = 1; tick();
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    reset = 1;
    bus.out_ready = 1;
    st(A_CTRL, 1);
    st(A_DATA, 32'h11);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_data", bus.out_data, 32'h11);
    st(A_DATA, 32'h22);
    chk("seq_data2", bus.out_data, 32'h22);
    st(A_DATA, 32'h33);
    chk("seq_data3", bus.out_data, 32'h33);
    idle();
    chk("t1_cnt", 32'(bus.store_cnt), 3);
    chk("t1_count", 32'(bus.fifo_count), 0);
    chk("t1_order", {mpop[0], mpop[1], mpop[2]} == {32'h11, 32'h22, 32'h33} ? 1 : 0, 1);
    bus.out_ready = 0;
    st(A_CTRL, 0);
    for (int i = 0; i < 9; i++) st(A_DATA, 32'hA0 + i);
    chk("t2_count", 32'(bus.fifo_count), 8);
    chk("t2_ovf", 32'(bus.overflow), 1);
    chk("t2_cnt", 32'(bus.store_cnt), 11);
    mpop.delete();
    bus.out_ready = 1;
    st(A_CTRL, 1);
    for (int i = 0; i < 9; i++) idle();
    chk("t2_npop", mpop.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_order", mpop[i], 32'hA0 + i);
    st(A_OVF, 0);
    chk("clr_ovf", 32'(bus.overflow), 0);
    st(A_CTRL, 0);
    for (int i = 0; i < 8; i++) st(A_DATA, 32'hB0 + i);
    st(A_CTRL, 1);
    st(A_DATA, 32'hBEEF);
    chk("t3_count", 32'(bus.fifo_count), 8);
    chk("t3_ovf", 32'(bus.overflow), 0);
    chk("t3_head", bus.out_data, 32'hB1);
    for (int i = 0; i < 8; i++) idle();
    chk("t3_tail", mpop[$], 32'hBEEF);
    s = 32'(bus.store_cnt);
    st(BASE + 32'h10, 32'h5);
    st(32'h0000_0100, 32'h5);
    chk("t4_count", 32'(bus.fifo_count), 0);
    chk("t4_cnt", 32'(bus.store_cnt), s);
    bus.out_ready = 0;
    st(A_CTRL, 0);
    for (int i = 0; i < 9; i++) st(A_DATA, 32'hC0 + i);
    st(A_CTRL, 2);
    chk("t5_flush0", 32'(bus.fifo_count), 0);
    for (int i = 0; i < 5; i++) st(A_DATA, 32'hD0 + i);
    chk("t5_five", 32'(bus.fifo_count), 5);
    st(A_CTRL, 3);
    chk("t5_count", 32'(bus.fifo_count), 0);
    chk("t5_valid", 32'(bus.out_valid), 0);
    chk("t5_ovf_kept", 32'(bus.overflow), 1);
    st(A_OVF, 1);
    chk("t5_ovf_clr", 32'(bus.overflow), 0);
    mpop.delete();
    for (int i = 0; i < 20; i++) begin
      bus.out_ready = 0;
      st(A_DATA, 32'h100 + i);
      bus.out_ready = 1;
      idle();
    end
    chk("t6_npop", mpop.size(), 20);
    for (int i = 0; i < 20; i++) chk("t6_order", mpop[i], 32'h100 + i);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) st(A_DATA, 32'hE0 + i);
    bus.out_ready = 1;
    reset = 0;
    tick();
    chk("rst_valid2", 32'(bus.out_valid), 0);
    chk("rst_data2", bus.out_data, 0);
    chk("rst_count2", 32'(bus.fifo_count), 0);
    chk("rst_drain2", 32'(bus.drain_en), 0);
    chk("rst_cnt2", 32'(bus.store_cnt), 0);
    reset = 1;
    idle();
    on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
